// File: rtl/zsequencer_pkg.sv
// Shared definitions for the zephyr byte sequencer: opcode and FSM state encodings
// plus the instruction-byte decoder.
package zsequencer_pkg;

  typedef enum logic [1:0] {
    OpLdi = 2'b00,
    OpMov = 2'b01,
    OpAdd = 2'b10,
    OpOut = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    StFetch = 3'd0,
    StImm   = 3'd1,
    StReadD = 3'd2,
    StReadS = 3'd3,
    StWrite = 3'd4,
    StEmit  = 3'd5
  } state_e;

  typedef struct packed {
    op_e        op;
    logic [1:0] rd;
    logic [1:0] rs;
  } instr_t;

  // Bits [1:0] of an instruction byte carry no meaning.
  function automatic instr_t decode(logic [7:0] b);
    instr_t d;
    d.op = op_e'(b[7:6]);
    d.rd = b[5:4];
    d.rs = b[3:2];
    return d;
  endfunction

endpackage

// File: rtl/zsequencer_zalu.sv
// 8-bit adder used by the sequencer's ADD instruction.
module zalu (
  input  logic [7:0] A,
  input  logic [7:0] B,
  output logic [7:0] SUM,
  output logic       COUT
);

  assign {COUT, SUM} = {1'b0, A} + {1'b0, B};

endmodule

// File: rtl/zsequencer.sv
// Byte-stream instruction sequencer driving an external 4 x 8-bit register file
// (LDI / MOV / ADD / OUT), with valid/ready handshakes on both streams.
module zsequencer
  import zsequencer_pkg::*;
(
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [7:0] INSTR,
  input  logic       INSTR_VALID,
  output logic       INSTR_READY,
  output logic [7:0] RF_IN,
  output logic       RF_OPCODE,
  output logic [1:0] RF_REG_SEL,
  input  logic [7:0] RF_OUT,
  output logic [7:0] RESULT,
  output logic       RESULT_VALID,
  input  logic       RESULT_READY,
  output logic       CARRY,
  output logic       BUSY
);

  state_e     state_q, state_d;
  instr_t     instr_q, instr_d;
  logic [7:0] a_q, a_d;
  logic [7:0] rf_in_q, rf_in_d;
  logic [1:0] sel_q, sel_d;
  logic [7:0] result_q, result_d;
  logic       carry_q, carry_d;

  logic [7:0] sum;
  logic       cout;
  instr_t     dec;
  logic       unused_instr_lsbs;

  assign dec               = decode(INSTR);
  assign unused_instr_lsbs = ^INSTR[1:0];

  zalu u_zalu (
    .A    (a_q),
    .B    (RF_OUT),
    .SUM  (sum),
    .COUT (cout)
  );

  // RF_REG_SEL is registered, so each transition preloads the select the next state needs.
  always_comb begin
    state_d      = state_q;
    instr_d      = instr_q;
    a_d          = a_q;
    rf_in_d      = rf_in_q;
    sel_d        = sel_q;
    result_d     = result_q;
    carry_d      = carry_q;
    INSTR_READY  = 1'b0;
    RF_OPCODE    = 1'b0;
    RESULT_VALID = 1'b0;

    unique case (state_q)
      StFetch: begin
        INSTR_READY = 1'b1;
        if (INSTR_VALID) begin
          instr_d = dec;
          unique case (dec.op)
            OpLdi: begin
              sel_d   = dec.rd;
              state_d = StImm;
            end
            OpAdd: begin
              sel_d   = dec.rd;
              state_d = StReadD;
            end
            OpMov, OpOut: begin
              sel_d   = dec.rs;
              state_d = StReadS;
            end
            default: state_d = StFetch;
          endcase
        end
      end
      StImm: begin
        INSTR_READY = 1'b1;
        if (INSTR_VALID) begin
          rf_in_d = INSTR;
          state_d = StWrite;
        end
      end
      StReadD: begin
        a_d     = RF_OUT;
        sel_d   = instr_q.rs;
        state_d = StReadS;
      end
      StReadS: begin
        unique case (instr_q.op)
          OpMov: begin
            rf_in_d = RF_OUT;
            sel_d   = instr_q.rd;
            state_d = StWrite;
          end
          OpAdd: begin
            rf_in_d = sum;
            carry_d = cout;
            sel_d   = instr_q.rd;
            state_d = StWrite;
          end
          OpOut: begin
            result_d = RF_OUT;
            state_d  = StEmit;
          end
          default: state_d = StFetch;
        endcase
      end
      StWrite: begin
        RF_OPCODE = 1'b1;
        state_d   = StFetch;
      end
      StEmit: begin
        RESULT_VALID = 1'b1;
        if (RESULT_READY) begin
          state_d = StFetch;
        end
      end
      default: state_d = StFetch;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= StFetch;
      instr_q  <= '0;
      a_q      <= '0;
      rf_in_q  <= '0;
      sel_q    <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      instr_q  <= instr_d;
      a_q      <= a_d;
      rf_in_q  <= rf_in_d;
      sel_q    <= sel_d;
      result_q <= result_d;
      carry_q  <= carry_d;
    end
  end

  assign RF_IN      = rf_in_q;
  assign RF_REG_SEL = sel_q;
  assign RESULT     = result_q;
  assign CARRY      = carry_q;
  assign BUSY       = (state_q != StFetch);

endmodule

// File: tb/tb_zsequencer.sv
// Self-checking bench for zsequencer: register-file model, result scoreboard,
// table-driven ADD vectors and hand-written handshake/reset sequences.
module tb_zsequencer;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic [7:0] INSTR = 8'h00;
  logic       INSTR_VALID = 1'b0;
  logic       INSTR_READY;
  logic [7:0] RF_IN;
  logic       RF_OPCODE;
  logic [1:0] RF_REG_SEL;
  logic [7:0] RF_OUT;
  logic [7:0] RESULT;
  logic       RESULT_VALID;
  logic       RESULT_READY = 1'b1;
  logic       CARRY;
  logic       BUSY;

  zsequencer dut (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .INSTR        (INSTR),
    .INSTR_VALID  (INSTR_VALID),
    .INSTR_READY  (INSTR_READY),
    .RF_IN        (RF_IN),
    .RF_OPCODE    (RF_OPCODE),
    .RF_REG_SEL   (RF_REG_SEL),
    .RF_OUT       (RF_OUT),
    .RESULT       (RESULT),
    .RESULT_VALID (RESULT_VALID),
    .RESULT_READY (RESULT_READY),
    .CARRY        (CARRY),
    .BUSY         (BUSY)
  );

  always #5 CLK = ~CLK;

  // External register file model
  logic [7:0] rf [4] = '{default: 8'h00};
  int         n_writes = 0;
  logic [1:0] last_sel = 2'd0;
  logic [7:0] last_data = 8'h00;

  assign RF_OUT = rf[RF_REG_SEL];

  always @(posedge CLK) begin
    if (RF_OPCODE) begin
      rf[RF_REG_SEL] <= RF_IN;
      n_writes       <= n_writes + 1;
      last_sel       <= RF_REG_SEL;
      last_data      <= RF_IN;
    end
  end

  int         n_checks = 0;
  int         n_pass = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Scoreboard: each accepted RESULT is compared with the oldest expected value.
  always @(negedge CLK) begin
    if (RST_N && RESULT_VALID && RESULT_READY) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL result_unexpected: got %0h, expected no result", RESULT);
      end else begin
        check("result", {24'h0, RESULT}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  // Call only just after a rising edge.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    INSTR       = b;
    INSTR_VALID = 1'b1;
    @(negedge CLK);
    while (!INSTR_READY && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (!INSTR_READY) check("instr_ready_timeout", {31'h0, INSTR_READY}, 32'h1);
    @(posedge CLK);
    #1;
    INSTR_VALID = 1'b0;
    INSTR       = 8'h00;
  endtask

  task automatic wait_idle(output int cycles);
    cycles = 0;
    while (BUSY && cycles < 50) begin
      @(posedge CLK);
      #1;
      cycles++;
    end
    if (BUSY) check("idle_timeout", {31'h0, BUSY}, 32'h0);
  endtask

  task automatic check_reset_outputs();
    check("rst_rf_in", {24'h0, RF_IN}, 32'h0);
    check("rst_rf_opcode", {31'h0, RF_OPCODE}, 32'h0);
    check("rst_rf_reg_sel", {30'h0, RF_REG_SEL}, 32'h0);
    check("rst_result", {24'h0, RESULT}, 32'h0);
    check("rst_result_valid", {31'h0, RESULT_VALID}, 32'h0);
    check("rst_carry", {31'h0, CARRY}, 32'h0);
    check("rst_busy", {31'h0, BUSY}, 32'h0);
    check("rst_instr_ready", {31'h0, INSTR_READY}, 32'h1);
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] sum;
    logic       carry;
  } add_vec_t;

  add_vec_t tbl[4];

  initial begin
    int c;
    int w0;

    tbl[0] = '{a: 8'hF0, b: 8'h20, sum: 8'h10, carry: 1'b1};
    tbl[1] = '{a: 8'h01, b: 8'h02, sum: 8'h03, carry: 1'b0};
    tbl[2] = '{a: 8'h80, b: 8'h7F, sum: 8'hFF, carry: 1'b0};
    tbl[3] = '{a: 8'hFF, b: 8'h01, sum: 8'h00, carry: 1'b1};

    // Reset values, both during and just after reset
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check_reset_outputs();
    RST_N = 1'b1;
    #1;
    check_reset_outputs();
    @(posedge CLK);
    #1;

    // LDI R0,0xAA then OUT R0
    w0 = n_writes;
    send_byte(8'h00);
    send_byte(8'hAA);
    wait_idle(c);
    check("ldi_latency", c, 1);
    check("ldi_write_count", n_writes - w0, 1);
    check("ldi_write_sel", {30'h0, last_sel}, 32'h0);
    check("ldi_write_data", {24'h0, last_data}, 32'hAA);
    exp_q.push_back(8'hAA);
    send_byte(8'hC0);
    wait_idle(c);
    check("out_latency", c, 2);

    // ADD table: LDI R1,a; LDI R2,b; ADD R1,R2; OUT R1
    for (int i = 0; i < 4; i++) begin
      send_byte(8'h10);
      send_byte(tbl[i].a);
      wait_idle(c);
      send_byte(8'h20);
      send_byte(tbl[i].b);
      wait_idle(c);
      send_byte(8'h98);
      wait_idle(c);
      check("add_latency", c, 3);
      check("add_carry", {31'h0, CARRY}, {31'h0, tbl[i].carry});
      check("add_rf_r1", {24'h0, rf[1]}, {24'h0, tbl[i].sum});
      exp_q.push_back(tbl[i].sum);
      send_byte(8'hC4);
      wait_idle(c);
    end

    // MOV R0,R1 with nonzero ignored bits; CARRY from the last ADD must hold
    send_byte(8'h47);
    wait_idle(c);
    check("mov_latency", c, 2);
    check("mov_carry_hold", {31'h0, CARRY}, 32'h1);
    check("mov_data", {24'h0, rf[0]}, 32'h00);

    // LDI R3,0x07; ADD R3,R3; MOV R0,R3; OUT R0
    send_byte(8'h30);
    send_byte(8'h07);
    wait_idle(c);
    send_byte(8'hBC);
    wait_idle(c);
    check("double_carry", {31'h0, CARRY}, 32'h0);
    check("double_rf_r3", {24'h0, rf[3]}, 32'h0E);
    send_byte(8'h4C);
    wait_idle(c);
    check("mov_rf_r0", {24'h0, rf[0]}, 32'h0E);
    exp_q.push_back(8'h0E);
    send_byte(8'hC0);
    wait_idle(c);

    // OUT R0 with RESULT_READY held low for 5 cycles
    RESULT_READY = 1'b0;
    exp_q.push_back(8'h0E);
    send_byte(8'hC0);
    @(posedge CLK);
    #1;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      check("stall_valid", {31'h0, RESULT_VALID}, 32'h1);
      check("stall_result", {24'h0, RESULT}, 32'h0E);
      check("stall_instr_ready", {31'h0, INSTR_READY}, 32'h0);
      @(posedge CLK);
      #1;
    end
    RESULT_READY = 1'b1;
    @(posedge CLK);
    #1;
    check("stall_release_busy", {31'h0, BUSY}, 32'h0);
    check("stall_release_valid", {31'h0, RESULT_VALID}, 32'h0);

    // LDI R2 with a 3-cycle gap before its immediate
    send_byte(8'h20);
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK);
      #1;
      check("gap_instr_ready", {31'h0, INSTR_READY}, 32'h1);
      check("gap_busy", {31'h0, BUSY}, 32'h1);
      check("gap_rf_opcode", {31'h0, RF_OPCODE}, 32'h0);
    end
    send_byte(8'h5A);
    wait_idle(c);
    check("gap_rf_r2", {24'h0, rf[2]}, 32'h5A);
    check("gap_write_sel", {30'h0, last_sel}, 32'h2);

    // Reset while waiting for an LDI immediate
    send_byte(8'h10);
    w0 = n_writes;
    @(negedge CLK);
    RST_N = 1'b0;
    #1;
    check_reset_outputs();
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    #1;
    check_reset_outputs();
    @(posedge CLK);
    #1;
    check("imm_abort_no_write", n_writes - w0, 0);

    // Reset while a RESULT is pending: it is discarded
    RESULT_READY = 1'b0;
    send_byte(8'hCC);
    @(posedge CLK);
    #1;
    check("emit_before_reset", {31'h0, RESULT_VALID}, 32'h1);
    check("emit_result_r3", {24'h0, RESULT}, 32'h0E);
    @(negedge CLK);
    RST_N = 1'b0;
    #1;
    check("emit_abort_valid", {31'h0, RESULT_VALID}, 32'h0);
    check("emit_abort_result", {24'h0, RESULT}, 32'h0);
    RESULT_READY = 1'b1;
    @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK);
    #1;
    check("emit_abort_idle", {31'h0, BUSY}, 32'h0);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
